// File: rtl/enc8to3_drain.sv
// Sequential 8-to-3 encoder. A request vector is captured into a pending
// register, then drained one code per accepted transfer in priority order.
// Codes use the decoder's mapping: line a[i] encodes to 7-i, and dec[0] is
// the MSB.
//
// state | meaning
// IDLE  | nothing pending; waiting for a load with a non-zero vector
// DRAIN | pending bits remain; offering the highest-priority code
module enc8to3_drain #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] a,
  input  logic       load,
  input  logic       selbar,
  input  logic       ready,
  output logic [0:2] dec,
  output logic       valid,
  output logic       busy,
  output logic       multi,
  output logic [3:0] remaining
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [0:7] pending_q, pending_d;
  logic [3:0] remaining_q, remaining_d;
  logic       multi_q, multi_d;
  logic [3:0] a_count;
  logic [2:0] idx;
  logic       xfer;

  // Population count of the request vector, used on capture.
  always_comb begin
    a_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      a_count = a_count + {3'b000, a[i]};
    end
  end

  // Index of the highest-priority pending line; the last match in the loop
  // wins, so the scan runs from the lowest priority towards the highest.
  always_comb begin
    idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) idx = i[2:0];
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) idx = i[2:0];
      end
    end
  end

  assign busy      = (state_q == DRAIN);
  assign valid     = busy & ~selbar;
  assign xfer      = valid & ready;
  assign dec       = valid ? (3'd7 - idx) : 3'd0;
  assign multi     = multi_q;
  assign remaining = remaining_q;

  // Next-state and datapath update: capture in IDLE, clear one bit per transfer.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    remaining_d = remaining_q;
    multi_d     = multi_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (a != 8'd0) begin
            pending_d   = a;
            remaining_d = a_count;
            multi_d     = (a_count > 4'd1);
            state_d     = DRAIN;
          end else begin
            multi_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (xfer && remaining_q != 4'd0) begin
          pending_d[idx] = 1'b0;
          remaining_d    = remaining_q - 4'd1;
          if (remaining_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards anything pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 8'd0;
      remaining_q <= 4'd0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      remaining_q <= remaining_d;
      multi_q     <= multi_d;
    end
  end

endmodule

// File: doc/enc8to3_drain.md
Name: enc8to3_drain

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder (`testdec`).
- Captures an 8-line request vector into a pending register and emits one 3-bit code per accepted transfer, in priority order, until the register is empty.
- Code mapping matches the decoder exactly: line `a[i]` encodes to `dec = 7-i`, where `dec[0]` is the MSB. Decoding an emitted code therefore reasserts the same line.
- Has the same active-low `selbar` select as the decoder. It sits between request sources and the decoder's select bus.

Parameters:
- `LSB_FIRST`, default 1: when 1, `a[0]` (code 7) has highest priority and `a[7]` (code 0) lowest. When 0, the order is reversed.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `a` input [0:7]: request lines; sampled only on a capture.
- `load` input 1: capture strobe; honoured only in IDLE.
- `selbar` input 1: active-low output enable.
- `ready` input 1: consumer accepts the current code.
- `dec` output [0:2]: encoded code of the highest-priority pending line.
- `valid` output 1: `dec` is meaningful and offered.
- `busy` output 1: state is DRAIN.
- `multi` output 1: the last captured vector had more than one bit set.
- `remaining` output 4: popcount of the pending register (0..8).

Behaviour:
- Reset (`rst`=1, asynchronous): pending register = 0, state = IDLE. All outputs then read 0: `dec`, `valid`, `busy`, `multi`, `remaining`. A reset mid-DRAIN discards all pending bits.
- States: IDLE, DRAIN.
- IDLE with `load`=1 and `a` != 0:
  - pending <= `a`;
  - `multi` <= (popcount(`a`) > 1);
  - next state DRAIN.
- IDLE with `load`=1 and `a` == 0: no capture, stay in IDLE, `multi` <= 0.
- IDLE with `load`=0: hold all state.
- DRAIN, combinational outputs:
  - `dec` = 7 − (index of the highest-priority set pending bit);
  - `valid` = ~`selbar`;
  - `busy` = 1.
- DRAIN, transfer (`valid` & `ready`) at an edge:
  - clear that pending bit and decrement `remaining`;
  - if it was the last set bit, next state IDLE; otherwise stay in DRAIN and present the next code on the following cycle.
- One transfer per cycle at most. Back-to-back transfers are allowed with `ready` held high.
- Latency: `load` sampled at edge N → `valid` high in cycle N+1, if `selbar`=0.
- `load` during DRAIN is ignored; `a` is not resampled and `multi` is unchanged.
- `selbar`=1:
  - `valid`=0 and `dec`=0;
  - pending contents and state are frozen, and no transfer occurs even if `ready`=1;
  - draining resumes from the same bit once `selbar` returns to 0.
  - Captures in IDLE are still honoured while `selbar`=1.
- Outside DRAIN: `dec`=0, `valid`=0, `busy`=0.
- `remaining` is a registered 4-bit count:
  - loaded with popcount(`a`) on capture;
  - decremented by exactly 1 per transfer;
  - never wraps below 0;
  - equals 0 exactly when the state is IDLE.
- A `ready`=1 with `valid`=0 has no effect.

Test Plan:
- Single line: reset, then `load`=1 with `a`=8'b0010_0000 (`a[2]`) and `selbar`=0, `ready`=1 → next cycle `dec`=3'b101, `valid`=1, `multi`=0, `remaining`=1. One cycle later the block is back in IDLE with `valid`=0 and `busy`=0.
- Multi-hot drain (`LSB_FIRST`=1): `a`=8'b1000_0011 → `multi`=1, `remaining`=3. `dec` sequence over three consecutive `ready` cycles is 7, 1, 0; `remaining` goes 3, 2, 1, then 0 (IDLE).
- Backpressure and select: mid-drain of `a`=8'b0101_0000, hold `ready`=0 for 3 cycles → `dec`=6 stable, `valid`=1. Then hold `selbar`=1 with `ready`=1 for 2 cycles → `valid`=0, `dec`=0, `remaining` stays 2. Then `selbar`=0 → `dec`=6 is transferred, followed by `dec`=4.
- Ignored load and zero load: pulse `load` with `a`=8'hFF during a DRAIN of `a`=8'b0000_0001 → only `dec`=0 is emitted. Then `load` with `a`=0 in IDLE → `busy` stays 0 and `multi`=0.
- Reset mid-operation: assert `rst` asynchronously (between edges) during a drain with `remaining`=5 → `valid`, `dec`, `busy`, `multi` and `remaining` go to 0 immediately. The first `load` after release behaves as in the single-line scenario.
- `LSB_FIRST`=0 variant: `a`=8'b1000_0011 → `dec` sequence is 0, 1, 7.
